// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg: shared ALU control codes and HI/LO unit state encoding
package alu_muldiv_pkg;
    localparam int ALU_CTRL_W = 6;
    localparam logic [ALU_CTRL_W-1:0] ALU_MFHI  = 6'b010000;
    localparam logic [ALU_CTRL_W-1:0] ALU_MTHI  = 6'b010001;
    localparam logic [ALU_CTRL_W-1:0] ALU_MFLO  = 6'b010010;
    localparam logic [ALU_CTRL_W-1:0] ALU_MTLO  = 6'b010011;
    localparam logic [ALU_CTRL_W-1:0] ALU_MULT  = 6'b011000;
    localparam logic [ALU_CTRL_W-1:0] ALU_MULTU = 6'b011001;
    localparam logic [ALU_CTRL_W-1:0] ALU_DIV   = 6'b011010;
    localparam logic [ALU_CTRL_W-1:0] ALU_DIVU  = 6'b011011;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} md_state_t;
endpackage

// File: rtl/alu_muldiv_step.sv
// muldiv_step: one radix-2 shift-add multiply or restoring shift-subtract divide iteration
module muldiv_step #(
    parameter int W = 32
) (
    input  logic         i_div,
    input  logic [W-1:0] i_hi,
    input  logic [W-1:0] i_lo,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);
    logic [W:0]   w_sum;
    logic [W:0]   w_sh;
    logic [W+1:0] w_diff;
    logic         w_qbit;
    always_comb begin
        w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
        w_sh   = {i_hi, i_lo[W-1]};
        w_diff = {1'b0, w_sh} - {2'b0, i_b};
        w_qbit = ~w_diff[W+1];
        o_hi   = i_div ? (w_qbit ? w_diff[W-1:0] : w_sh[W-1:0]) : w_sum[W:1];
        o_lo   = i_div ? {i_lo[W-2:0], w_qbit} : {w_sum[0], i_lo[W-1:1]};
    end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative HI/LO multiply/divide unit with MFHI/MFLO/MTHI/MTLO and pipeline stall
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int DATA_BUS_WIDTH     = 32,
    parameter int ALU_CTRL_BUS_WIDTH = 6
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_start,
    input  logic [ALU_CTRL_BUS_WIDTH-1:0] i_alu_ctrl,
    input  logic [DATA_BUS_WIDTH-1:0]     i_data_a,
    input  logic [DATA_BUS_WIDTH-1:0]     i_data_b,
    output logic [DATA_BUS_WIDTH-1:0]     o_result,
    output logic                          o_busy,
    output logic                          o_stall,
    output logic                          o_done,
    output logic [DATA_BUS_WIDTH-1:0]     o_hi,
    output logic [DATA_BUS_WIDTH-1:0]     o_lo
);
    localparam int W  = DATA_BUS_WIDTH;
    localparam int CW = $clog2(W);
    md_state_t       r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_hi, r_lo, r_acc_hi, r_acc_lo, r_b;
    logic            r_div, r_neg_a, r_neg_b, r_done;
    logic            w_mul_op, w_div_op, w_signed, w_any_op, w_accept;
    logic            w_mfhi, w_mflo, w_mthi, w_mtlo;
    logic [W-1:0]    w_abs_a, w_abs_b, w_step_hi, w_step_lo, w_fin_hi, w_fin_lo;
    logic [2*W-1:0]  w_prod;
    always_comb begin
        w_mfhi   = i_alu_ctrl == ALU_MFHI;
        w_mflo   = i_alu_ctrl == ALU_MFLO;
        w_mthi   = i_alu_ctrl == ALU_MTHI;
        w_mtlo   = i_alu_ctrl == ALU_MTLO;
        w_mul_op = i_alu_ctrl == ALU_MULT || i_alu_ctrl == ALU_MULTU;
        w_div_op = i_alu_ctrl == ALU_DIV || i_alu_ctrl == ALU_DIVU;
        w_signed = i_alu_ctrl == ALU_MULT || i_alu_ctrl == ALU_DIV;
        w_any_op = w_mul_op | w_div_op | w_mfhi | w_mflo | w_mthi | w_mtlo;
        w_accept = i_start && r_state == S_IDLE && (w_mul_op || w_div_op);
        w_abs_a  = (w_signed && i_data_a[W-1]) ? -i_data_a : i_data_a;
        w_abs_b  = (w_signed && i_data_b[W-1]) ? -i_data_b : i_data_b;
    end
    muldiv_step #(.W(W)) u_step (
        .i_div (r_div),
        .i_hi  (r_acc_hi),
        .i_lo  (r_acc_lo),
        .i_b   (r_b),
        .o_hi  (w_step_hi),
        .o_lo  (w_step_lo)
    );
    // Low half of a negated 2W-bit value is the negated low half, so the quotient reuses w_prod.
    always_comb begin
        w_prod   = (r_neg_a ^ r_neg_b) ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
        w_fin_hi = r_div ? (r_neg_a ? -r_acc_hi : r_acc_hi) : w_prod[2*W-1:W];
        w_fin_lo = (r_div && r_b == '0) ? '1 : w_prod[W-1:0];
    end
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) r_state <= S_IDLE;
        else r_state <= w_next;
    always_comb
        w_next = r_state == S_IDLE ? (w_accept ? S_CALC : S_IDLE) :
                 r_state == S_CALC ? (r_cnt == CW'(W-1) ? S_DONE : S_CALC) : S_IDLE;
    always_comb begin
        o_busy   = r_state != S_IDLE;
        o_stall  = o_busy & i_start & w_any_op;
        o_done   = r_done;
        o_result = w_mfhi ? r_hi : w_mflo ? r_lo : '0;
        o_hi     = r_hi;
        o_lo     = r_lo;
    end
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_b      <= '0;
            r_div    <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= r_state == S_DONE;
            if (w_accept) begin
                r_cnt    <= '0;
                r_div    <= w_div_op;
                r_neg_a  <= w_signed & i_data_a[W-1];
                r_neg_b  <= w_signed & i_data_b[W-1];
                r_acc_hi <= '0;
                r_acc_lo <= w_abs_a;
                r_b      <= w_abs_b;
            end else if (r_state == S_CALC) begin
                r_cnt    <= r_cnt + 1'b1;
                r_acc_hi <= w_step_hi;
                r_acc_lo <= w_step_lo;
            end
            if (r_state == S_DONE) begin
                r_hi <= w_fin_hi;
                r_lo <= w_fin_lo;
            end else if (i_start && r_state == S_IDLE && w_mthi) r_hi <= i_data_a;
            else if (i_start && r_state == S_IDLE && w_mtlo) r_lo <= i_data_a;
        end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: randomized scoreboard bench for the HI/LO multiply/divide unit
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;
    localparam logic [5:0] NOP = 6'b000000;
    typedef struct {
        logic [63:0] val;
        int          cyc;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  ctrl = NOP;
    logic [31:0] da = '0, db = '0;
    logic [31:0] result, hi, lo;
    logic        busy, stall, done;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];

    alu_muldiv dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_start    (start),
        .i_alu_ctrl (ctrl),
        .i_data_a   (da),
        .i_data_b   (db),
        .o_result   (result),
        .o_busy     (busy),
        .o_stall    (stall),
        .o_done     (done),
        .o_hi       (hi),
        .o_lo       (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op == ALU_MULT) return sa * sb;
        if (op == ALU_MULTU) return ua * ub;
        if (b == 32'b0) return {a, 32'hFFFFFFFF};
        if (op == ALU_DIV) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no o_done expected o_done within 40 cycles");
        end
    endtask

    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; ctrl = op; da = a; db = b;
        @(posedge clk); #1;
        exp_q.push_back('{val: model(op, a, b), cyc: cyc});
        start = 1'b0; ctrl = NOP;
        wait_done();
    endtask

    always @(negedge clk) if (rst_n && done) begin
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: got o_done with hi=%h lo=%h expected no pulse", hi, lo);
        end else begin
            e = exp_q.pop_front();
            if ({hi, lo} !== e.val || cyc - e.cyc != 33) begin
                errors++;
                $display("FAIL scoreboard: got hi=%h lo=%h latency=%0d expected hi=%h lo=%h latency=33",
                         hi, lo, cyc - e.cyc, e.val[63:32], e.val[31:0]);
            end
        end
    end

    initial begin
        logic [63:0] m;
        logic [5:0]  ops[4];
        logic        stall_ok;
        int          n;
        ops[0] = ALU_MULT; ops[1] = ALU_MULTU; ops[2] = ALU_DIV; ops[3] = ALU_DIVU;
        start = 1'b1; ctrl = ALU_MULT; da = 32'h5; db = 32'h7;
        #2;
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_flags", {29'b0, busy, stall, done}, 0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1; start = 1'b0; ctrl = NOP;

        run_op(ALU_MULT, 32'hFFFFFFFD, 32'd7);
        chk("mult_neg_hi", hi, 32'hFFFFFFFF);
        chk("mult_neg_lo", lo, 32'hFFFFFFEB);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'b0, done}, 0);
        run_op(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_max_hi", hi, 32'hFFFFFFFE);
        chk("multu_max_lo", lo, 32'h00000001);
        run_op(ALU_DIV, 32'hFFFFFFF9, 32'd2);
        chk("div_neg_lo", lo, 32'hFFFFFFFD);
        chk("div_neg_hi", hi, 32'hFFFFFFFF);
        run_op(ALU_DIVU, 32'd100, 32'd0);
        chk("divu_zero_lo", lo, 32'hFFFFFFFF);
        chk("divu_zero_hi", hi, 32'd100);
        run_op(ALU_DIV, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'h0);
        run_op(ALU_DIV, 32'hFFFFFF00, 32'd0);

        m = model(ALU_MULT, 32'd123456, 32'hFFFF0000);
        start = 1'b1; ctrl = ALU_MULT; da = 32'd123456; db = 32'hFFFF0000;
        @(posedge clk); #1;
        exp_q.push_back('{val: m, cyc: cyc});
        start = 1'b0; ctrl = NOP;
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; ctrl = ALU_MFLO;
        stall_ok = 1'b1;
        n = 0;
        while (!done && n < 40) begin
            #1;
            if (!stall) stall_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        #1;
        chk("mflo_stall_held", {31'b0, stall_ok}, 1);
        chk("mflo_done_seen", {31'b0, done}, 1);
        chk("mflo_stall_released", {31'b0, stall}, 0);
        chk("mflo_result", result, m[31:0]);
        @(posedge clk); #1;

        start = 1'b1; ctrl = ALU_DIVU; da = 32'hDEADBEEF; db = 32'd13;
        @(posedge clk); #1;
        ctrl = ALU_MFHI;
        repeat (14) @(posedge clk);
        #1;
        chk("mid_calc_busy", {30'b0, busy, stall}, 3);
        rst_n = 1'b0;
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {29'b0, busy, stall, done}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0; ctrl = NOP;

        start = 1'b1; ctrl = ALU_MTHI; da = 32'h12345678;
        @(posedge clk); #1;
        ctrl = ALU_MFHI; da = 32'h0;
        #1;
        chk("mthi_mfhi_result", result, 32'h12345678);
        chk("mthi_no_done", {31'b0, done}, 0);
        ctrl = ALU_MTLO; da = 32'hCAFEBABE;
        @(posedge clk); #1;
        ctrl = ALU_MFLO;
        #1;
        chk("mtlo_mflo_result", result, 32'hCAFEBABE);
        chk("mtlo_hi_kept", hi, 32'h12345678);
        chk("mtlo_no_done", {31'b0, done}, 0);
        start = 1'b0; ctrl = NOP;
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
            run_op(ops[$urandom_range(0, 3)], a, b);
        end
        @(posedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter DATA_BUS_WIDTH, default 32, meaning operand/HI/LO width.
REQ-002 SHALL have parameter ALU_CTRL_BUS_WIDTH, default 6, meaning width of the ALU control code from alu_ctrl.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_start  input  1  EX-stage op valid this cycle.
REQ-006 SHALL have port i_alu_ctrl  input  ALU_CTRL_BUS_WIDTH  ALU control code from alu_ctrl.
REQ-007 SHALL have port i_data_a  input  DATA_BUS_WIDTH  rs operand (dividend/multiplicand).
REQ-008 SHALL have port i_data_b  input  DATA_BUS_WIDTH  rt operand (divisor/multiplier).
REQ-009 SHALL have port o_result  output  DATA_BUS_WIDTH  HI for MFHI, LO for MFLO, else 0.
REQ-010 SHALL have port o_busy  output  1  iterative operation in progress.
REQ-011 SHALL have port o_stall  output  1  pipeline hold request to hazard unit.
REQ-012 SHALL have port o_done  output  1  one-cycle pulse: new HI/LO visible.
REQ-013 SHALL have ports o_hi, o_lo  output  DATA_BUS_WIDTH  architectural HI/LO registers.

Function
REQ-014 SHALL decode codes: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011; all others ignored.
REQ-015 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-016 SHALL accept MULT/MULTU/DIV/DIVU only when i_start=1 and state is IDLE: latch |operands| and signs, clear 5-bit counter, go to CALC.
REQ-017 SHALL in CALC perform one shift-add (mult) or restoring shift-subtract (div) step per cycle, 32 steps, counter 0..31; after step 31 go to DONE.
REQ-018 SHALL in DONE apply sign correction and write HI/LO at the DONE->IDLE edge; o_done=1 in the following cycle only.
REQ-019 SHALL have latency: start edge k -> HI/LO and o_done valid after edge k+33.
REQ-020 SHALL produce MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product.
REQ-021 SHALL produce DIV/DIVU: LO=quotient, HI=remainder; signed quotient sign = sign(a)^sign(b), remainder sign = sign(a).
REQ-022 SHALL on divide-by-zero still take 33 cycles and give LO=32'hFFFFFFFF, HI=i_data_a.
REQ-023 SHALL give DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-024 SHALL execute MTHI/MTLO in IDLE with i_start=1 by writing i_data_a to HI/LO at that edge, without o_done.
REQ-025 SHALL drive o_result combinationally from current HI/LO.
REQ-026 SHALL assert o_busy when state is CALC or DONE.
REQ-027 SHALL assert o_stall = o_busy & i_start & (any decoded op); a new op arriving while busy is held, not dropped or queued.
REQ-028 SHALL set o_stall=0 and o_busy=0 when idle, so back-to-back start is possible the cycle after o_done.

Reset
REQ-029 SHALL on i_reset_n=0, at any time including mid-CALC, immediately force IDLE, counter=0, HI=LO=0, o_done=0, o_busy=0, o_stall=0; in-flight op lost.
REQ-030 SHALL require first accepted op after release at first rising edge with i_reset_n=1.

Structure
REQ-031 SHALL take op codes and FSM state encodings from the shared mips package already holding alu_ctrl codes; no local literals.
REQ-032 SHALL use one sub-module, muldiv_step: combinational single iteration (mult/div select, partial remainder/product, quotient bit).
REQ-033 SHALL keep the size around 200-300 RTL lines.

Verification
REQ-034 SHALL cover MULT a=-3 (0xFFFFFFFD), b=7 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB, o_done one cycle.
REQ-035 SHALL cover MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 SHALL cover DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/0 -> LO=0xFFFFFFFF, HI=100.
REQ-037 SHALL cover MFLO issued 5 cycles after MULT start -> o_stall=1 until o_done cycle, then o_result=LO.
REQ-038 SHALL cover reset pulsed at CALC count 15 -> all outputs 0 same cycle, HI/LO=0, state IDLE.
REQ-039 SHALL cover MTHI 0x12345678 then MFHI next cycle -> o_result=0x12345678, o_done stays 0.
